// File: rtl/reg_bank_wb_scheduler.sv
// ---------------------------------------------------------------------------
// reg_bank_wb_scheduler
// Shares the single write port of the register bank (Rw/WE_Reg/dIN) between
// two writeback requesters: req0 (ALU result) and req1 (load data). The two
// are arbitrated round-robin, and the winning write is registered one cycle
// before it reaches the bank. A pending-write scoreboard lets decode stall
// reads of registers whose producer has not yet written back.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req0_valid/addr/data, ready    ALU writeback handshake (ready is comb)
//   req1_valid/addr/data, ready    load writeback handshake (ready is comb)
//   iss_valid, iss_rd              issued instruction with a destination
//   rd_a, rd_b                     decode read addresses
//   stall_a, stall_b               read address has an outstanding write
//   wb_we, wb_rw, wb_din           registered bank write port
//   busy                           any write outstanding
// ---------------------------------------------------------------------------
module reg_bank_wb_scheduler #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] rd_a,
    input  logic [ADDR_W-1:0] rd_b,
    output logic              stall_a,
    output logic              stall_b,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_rw,
    output logic [DATA_W-1:0] wb_din,
    output logic              busy
);

    logic              r_rr_ptr;
    logic [NREG-1:0]   r_pending;
    logic              r_wb_we;
    logic [ADDR_W-1:0] r_wb_rw;
    logic [DATA_W-1:0] r_wb_din;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_acc;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_data;
    logic [NREG-1:0]   w_pending_nxt;

    // Round-robin grant: a lone requester always wins, a tie goes to rr_ptr.
    always_comb begin
        w_grant0   = 1'b0;
        w_grant1   = 1'b0;
        if (!rst) begin
            w_grant0 = req0_valid && (!req1_valid || !r_rr_ptr);
            w_grant1 = req1_valid && (!req0_valid ||  r_rr_ptr);
        end
        w_acc      = w_grant0 || w_grant1;
        w_acc_addr = w_grant1 ? req1_addr : req0_addr;
        w_acc_data = w_grant1 ? req1_data : req0_data;
    end

    // Scoreboard update: clear on accept, then set on issue so a new
    // producer of the same register stays outstanding. Register 0 never pends.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_acc) begin
            w_pending_nxt[w_acc_addr] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            w_pending_nxt[iss_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Write-port staging, arbitration pointer and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= 1'b0;
            r_pending <= '0;
            r_wb_we   <= 1'b0;
            r_wb_rw   <= '0;
            r_wb_din  <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            // Writes to register 0 complete the handshake but never reach the bank.
            r_wb_we   <= w_acc && (w_acc_addr != '0);
            if (w_acc) begin
                r_wb_rw  <= w_acc_addr;
                r_wb_din <= w_acc_data;
                // Favour whichever requester lost (or did not ask) this time.
                r_rr_ptr <= w_grant0;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign stall_a    = r_pending[rd_a];
    assign stall_b    = r_pending[rd_b];
    assign busy       = |r_pending[NREG-1:1];
    assign wb_we      = r_wb_we;
    assign wb_rw      = r_wb_rw;
    assign wb_din     = r_wb_din;

endmodule

// File: tb/tb_reg_bank_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_wb_scheduler
// Directed scenarios plus constrained-random traffic. A negedge monitor keeps
// a reference model of the arbiter and scoreboard; every cycle it pushes the
// expected write-port contents into a queue and pops them one cycle later
// when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_reg_bank_wb_scheduler;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREG   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic [ADDR_W-1:0] rd_a;
    logic [ADDR_W-1:0] rd_b;
    logic              stall_a;
    logic              stall_b;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_rw;
    logic [DATA_W-1:0] wb_din;
    logic              busy;

    always #5 clk = ~clk;

    reg_bank_wb_scheduler #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .stall_a    (stall_a),
        .stall_b    (stall_b),
        .wb_we      (wb_we),
        .wb_rw      (wb_rw),
        .wb_din     (wb_din),
        .busy       (busy)
    );

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] rw;
        logic [DATA_W-1:0] din;
    } wb_t;

    wb_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state (value for the current cycle).
    logic              m_rr;
    logic [NREG-1:0]   m_pend;
    logic [ADDR_W-1:0] m_rw;
    logic [DATA_W-1:0] m_din;
    bit                m_known = 1'b0;
    logic              m_g0, m_g1;
    logic [ADDR_W-1:0] m_a;
    logic [DATA_W-1:0] m_d;
    wb_t               m_e;

    always @(negedge clk) begin
        if (m_known) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 64'(exp_q.size()), 64'd1);
            end else begin
                m_e = exp_q.pop_front();
                check("sb_wb_we",  64'(wb_we),  64'(m_e.we));
                check("sb_wb_rw",  64'(wb_rw),  64'(m_e.rw));
                check("sb_wb_din", wb_din,      m_e.din);
            end
            check("sb_stall_a", 64'(stall_a), 64'(m_pend[rd_a]));
            check("sb_stall_b", 64'(stall_b), 64'(m_pend[rd_b]));
            check("sb_busy",    64'(busy),    64'(|m_pend));
        end
        m_g0 = !rst && req0_valid && (!req1_valid || (m_rr == 1'b0));
        m_g1 = !rst && req1_valid && (!req0_valid || (m_rr == 1'b1));
        if (m_known || rst) begin
            check("sb_ready0", 64'(req0_ready), 64'(m_g0));
            check("sb_ready1", 64'(req1_ready), 64'(m_g1));
        end
        if (rst) begin
            m_rr    = 1'b0;
            m_pend  = '0;
            m_rw    = '0;
            m_din   = '0;
            exp_q.delete();
            exp_q.push_back('{1'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}});
            m_known = 1'b1;
        end else if (m_known) begin
            m_a = m_g1 ? req1_addr : req0_addr;
            m_d = m_g1 ? req1_data : req0_data;
            if (m_g0 || m_g1) begin
                m_rr  = m_g0;
                m_rw  = m_a;
                m_din = m_d;
                m_pend[m_a] = 1'b0;
            end
            if (iss_valid && (iss_rd != 0)) m_pend[iss_rd] = 1'b1;
            exp_q.push_back('{(m_g0 || m_g1) && (m_a != 0), m_rw, m_din});
        end
    end

    // Waits (bounded) for the chosen requester's ready; returns at that negedge.
    task automatic wait_ready(input bit which, input string tag);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((which ? req1_ready : req0_ready) === 1'b1) break;
            n++;
            if (n >= 8) begin
                check({tag, "_timeout"}, 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit acc0, acc1;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 64'h11;
        req1_valid = 1'b0; req1_addr = '0;   req1_data = '0;
        iss_valid = 1'b0;  iss_rd = '0; rd_a = '0; rd_b = '0;

        // T1: reset held two cycles with req0 asking.
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("t1_ready0", 64'(req0_ready), 64'd0);
        check("t1_wb_we",  64'(wb_we),      64'd0);
        check("t1_wb_rw",  64'(wb_rw),      64'd0);
        check("t1_wb_din", wb_din,          64'd0);
        check("t1_busy",   64'(busy),       64'd0);
        step(); rst = 1'b0;
        @(negedge clk);
        check("t1_grant", 64'(req0_ready), 64'd1);
        step(); req0_valid = 1'b0;
        @(negedge clk);
        check("t1_wb", 64'(wb_rw), 64'd4);

        // T2: single ALU write, one-cycle latency, single-cycle pulse.
        step(); req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'hDEAD_BEEF;
        wait_ready(1'b0, "t2");
        step(); req0_valid = 1'b0;
        @(negedge clk);
        check("t2_we",  64'(wb_we), 64'd1);
        check("t2_rw",  64'(wb_rw), 64'd5);
        check("t2_din", wb_din,     64'hDEAD_BEEF);
        @(negedge clk);
        check("t2_we_off", 64'(wb_we), 64'd0);

        // T4: write to x0 handshakes but does not enable the bank.
        step(); req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 64'd7;
        wait_ready(1'b1, "t4");
        check("t4_ready1", 64'(req1_ready), 64'd1);
        step(); req1_valid = 1'b0;
        @(negedge clk);
        check("t4_we",  64'(wb_we), 64'd0);
        check("t4_din", wb_din,     64'd7);

        // T3: contention; req1 won last, so req0 goes first, then alternate.
        step();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'h100;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'h200;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("t3_we", 64'(wb_we), 64'd1);
                check("t3_rw", 64'(wb_rw), ((i - 1) % 2 == 0) ? 64'd1 : 64'd2);
            end
            if (i < 4) begin
                check("t3_ready0", 64'(req0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
                check("t3_ready1", 64'(req1_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            end
            step();
            if (i < 4) begin
                if (i % 2 == 0) req0_data = req0_data + 64'd1;
                else            req1_data = req1_data + 64'd1;
            end
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end

        // T5: scoreboard set by issue, cleared by the load writeback.
        rd_a = 5'd9; iss_valid = 1'b1; iss_rd = 5'd9;
        step(); iss_valid = 1'b0;
        @(negedge clk);
        check("t5_stall_set", 64'(stall_a), 64'd1);
        check("t5_busy_set",  64'(busy),    64'd1);
        step(); step();
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 64'h99;
        wait_ready(1'b1, "t5");
        check("t5_stall_hold", 64'(stall_a), 64'd1);
        step(); req1_valid = 1'b0;
        @(negedge clk);
        check("t5_stall_clr", 64'(stall_a), 64'd0);
        check("t5_busy_clr",  64'(busy),    64'd0);

        // T6: set and clear of the same register on one edge; set wins.
        step(); iss_valid = 1'b1; iss_rd = 5'd3; rd_b = 5'd3;
        step();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h33;
        @(negedge clk);
        check("t6_ready0", 64'(req0_ready), 64'd1);
        check("t6_pre",    64'(stall_b),    64'd1);
        step(); req0_valid = 1'b0; iss_valid = 1'b0;
        @(negedge clk);
        check("t6_stall_b", 64'(stall_b), 64'd1);
        check("t6_we",      64'(wb_we),   64'd1);
        check("t6_rw",      64'(wb_rw),   64'd3);

        // Reset in the middle of traffic drops everything outstanding.
        step(); iss_valid = 1'b1; iss_rd = 5'd7;
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 64'h66;
        step(); iss_valid = 1'b0; rst = 1'b1;
        step(); rst = 1'b0; req0_valid = 1'b0;
        @(negedge clk);
        check("t6_rst_busy",  64'(busy),    64'd0);
        check("t6_rst_we",    64'(wb_we),   64'd0);
        check("t6_rst_stall", 64'(stall_b), 64'd0);

        // Random traffic that honours the hold-until-accepted rule.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            step();
            if (!req0_valid || acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_addr  = ADDR_W'($urandom_range(0, 7));
                req0_data  = {32'($urandom), 32'($urandom)};
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_addr  = ADDR_W'($urandom_range(0, 7));
                req1_data  = {32'($urandom), 32'($urandom)};
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = ADDR_W'($urandom_range(0, 7));
            rd_a      = ADDR_W'($urandom_range(0, 7));
            rd_b      = ADDR_W'($urandom_range(0, 7));
        end

        // Drain: stop requesting once current ones are accepted.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            step();
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            iss_valid = 1'b0;
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
